// File: rtl/lfsr_rr_server.sv
// Shared pseudo-random word server: one XNOR LFSR, seeded and stepped here,
// whose successive words are handed out round-robin to NUM_REQ requesters.

module lfsr #(
  parameter int NUM_BITS = 32
) (
  input  logic                clk,
  input  logic                enable,
  input  logic                seed_dv,
  input  logic [NUM_BITS-1:0] seed_data,
  output logic [NUM_BITS-1:0] lfsr_data,
  output logic                done
);

  function automatic logic [63:0] tap(input int n);
    return 64'd1 << (n - 1);
  endfunction

  // Maximal-length XNOR tap sets; the all-ones word is the lock-up state.
  function automatic logic [63:0] tap_mask(input int n);
    case (n)
      3:  return tap(3)  | tap(2);
      4:  return tap(4)  | tap(3);
      5:  return tap(5)  | tap(3);
      6:  return tap(6)  | tap(5);
      7:  return tap(7)  | tap(6);
      8:  return tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  return tap(9)  | tap(5);
      10: return tap(10) | tap(7);
      11: return tap(11) | tap(9);
      12: return tap(12) | tap(6)  | tap(4)  | tap(1);
      13: return tap(13) | tap(4)  | tap(3)  | tap(1);
      14: return tap(14) | tap(5)  | tap(3)  | tap(1);
      15: return tap(15) | tap(14);
      16: return tap(16) | tap(15) | tap(13) | tap(4);
      17: return tap(17) | tap(14);
      18: return tap(18) | tap(11);
      19: return tap(19) | tap(6)  | tap(2)  | tap(1);
      20: return tap(20) | tap(17);
      21: return tap(21) | tap(19);
      22: return tap(22) | tap(21);
      23: return tap(23) | tap(18);
      24: return tap(24) | tap(23) | tap(22) | tap(17);
      25: return tap(25) | tap(22);
      26: return tap(26) | tap(6)  | tap(2)  | tap(1);
      27: return tap(27) | tap(5)  | tap(2)  | tap(1);
      28: return tap(28) | tap(25);
      29: return tap(29) | tap(27);
      30: return tap(30) | tap(6)  | tap(4)  | tap(1);
      31: return tap(31) | tap(28);
      32: return tap(32) | tap(22) | tap(2)  | tap(1);
      64: return tap(64) | tap(63) | tap(61) | tap(60);
      default: return 64'd0;
    endcase
  endfunction

  localparam logic [63:0]         TAPS_ALL = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS     = TAPS_ALL[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] r;
  logic                fb;

  assign fb = ~^(r & TAPS);

  always_ff @(posedge clk) begin
    if (enable) r <= seed_dv ? seed_data : {r[NUM_BITS-2:0], fb};
  end

  assign lfsr_data = r;
  assign done      = (r == seed_data);

endmodule

module lfsr_rr_server #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4,
  parameter int WARMUP   = 16,
  parameter int STRIDE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_wr,
  input  logic [NUM_BITS-1:0] seed_data,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [NUM_BITS-1:0] rnd_data,
  output logic                rnd_valid,
  output logic                busy,
  output logic                wrapped,
  output logic                seed_err
);

  // Handshake: req is a level held by each requester; gnt is a registered
  // one-hot pulse, and rnd_data is valid in the gnt cycle and held after it.
  // A requester may keep req high to take every word it is granted.

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {UNSEEDED, LOAD, WARM, READY, STEP} state_t;

  state_t              state, state_n;
  logic [NUM_BITS-1:0] seed_q, lfsr_word;
  logic                lfsr_en, lfsr_load, lfsr_done;
  logic [PW-1:0]       ptr;
  logic [31:0]         cnt;
  logic                adv_seen;
  logic                seed_ok, seed_bad, take_seed, do_grant;
  logic [PW:0]         pick;

  // Winner is the set bit at the smallest rotational distance past ptr.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0]      p);
    int          best, d;
    logic [PW:0] res;
    best = NUM_REQ;
    res  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (r[j]) begin
        d = (j + 2 * NUM_REQ - int'(p) - 1) % NUM_REQ;
        if (d < best) begin
          best = d;
          res  = {1'b1, PW'(j)};
        end
      end
    end
    return res;
  endfunction

  lfsr #(.NUM_BITS(NUM_BITS)) u_lfsr (
    .clk       (clk),
    .enable    (lfsr_en),
    .seed_dv   (lfsr_load),
    .seed_data (seed_q),
    .lfsr_data (lfsr_word),
    .done      (lfsr_done)
  );

  assign seed_ok  = seed_wr && (seed_data != '1);
  assign seed_bad = seed_wr && (seed_data == '1);
  assign pick     = rr_pick(req, ptr);

  always_comb begin
    state_n   = state;
    lfsr_en   = 1'b0;
    lfsr_load = 1'b0;
    take_seed = 1'b0;
    do_grant  = 1'b0;
    case (state)
      UNSEEDED: begin
        if (seed_ok) begin
          take_seed = 1'b1;
          state_n   = LOAD;
        end
      end
      LOAD: begin
        lfsr_en   = 1'b1;
        lfsr_load = 1'b1;
        state_n   = (WARMUP == 0) ? READY : WARM;
      end
      WARM: begin
        lfsr_en = 1'b1;
        if (cnt == 32'(WARMUP - 1)) state_n = READY;
      end
      READY: begin
        if (pick[PW]) begin
          do_grant = 1'b1;
          state_n  = STEP;
        end
      end
      STEP: begin
        lfsr_en = 1'b1;
        if (cnt == 32'(STRIDE - 1)) state_n = READY;
      end
      default: state_n = UNSEEDED;
    endcase
    // A valid reseed overrides whatever the current state decided.
    if (seed_ok && state != UNSEEDED) begin
      take_seed = 1'b1;
      do_grant  = 1'b0;
      state_n   = LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UNSEEDED;
      seed_q   <= '0;
      gnt      <= '0;
      rnd_data <= '0;
      ptr      <= PW'(NUM_REQ - 1);
      cnt      <= '0;
      adv_seen <= 1'b0;
      wrapped  <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n == state) ? cnt + 32'd1 : 32'd0;
      if (take_seed) seed_q <= seed_data;
      for (int j = 0; j < NUM_REQ; j++) gnt[j] <= do_grant && (pick[PW-1:0] == PW'(j));
      if (do_grant) begin
        rnd_data <= lfsr_word;
        ptr      <= pick[PW-1:0];
      end
      if (state == LOAD) adv_seen <= 1'b0;
      else if (lfsr_en)  adv_seen <= 1'b1;
      // adv_seen keeps the freshly loaded seed from counting as a wrap.
      if (state == LOAD)              wrapped <= 1'b0;
      else if (adv_seen && lfsr_done) wrapped <= 1'b1;
      if (seed_bad)           seed_err <= 1'b1;
      else if (state == LOAD) seed_err <= 1'b0;
    end
  end

  assign rnd_valid = |gnt;
  assign busy      = (state != READY);

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Bench for lfsr_rr_server (4-bit LFSR, 4 requesters, warm-up 2, stride 1):
// directed scenarios plus random traffic against an edge-level reference model.

module tb_lfsr_rr_server;

  localparam int NB = 4;
  localparam int NR = 4;
  localparam int WU = 2;
  localparam int ST = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_wr;
  logic [NB-1:0] seed_data;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [NB-1:0] rnd_data;
  logic          rnd_valid, busy, wrapped, seed_err;

  always #5 clk = ~clk;

  lfsr_rr_server #(.NUM_BITS(NB), .NUM_REQ(NR), .WARMUP(WU), .STRIDE(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_wr   (seed_wr),
    .seed_data (seed_data),
    .req       (req),
    .gnt       (gnt),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .busy      (busy),
    .wrapped   (wrapped),
    .seed_err  (seed_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [NB-1:0] exp_q[$];
  logic [NB-1:0] seen_rnd[$];
  logic [NR-1:0] seen_gnt[$];
  int            seen_edge[$];
  logic          seen_wrap[$];

  // Reference model, tracked in edges since time zero.
  int            ecnt = 0;
  bit            m_seeded;
  logic [NB-1:0] m_seed;
  int            m_seed_edge, m_ready_edge, m_adv, m_last;
  logic [NR-1:0] m_gnt;
  logic [NB-1:0] m_rnd;
  logic          m_wrap, m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Word reached after k advances from seed s (4-bit XNOR sequence, period 15).
  function automatic logic [NB-1:0] lfsr_after(input logic [NB-1:0] s, input int k);
    logic [NB-1:0] x;
    x = s;
    for (int i = 0; i < (k % 15); i++) x = {x[2:0], ~(x[3] ^ x[2])};
    return x;
  endfunction

  task automatic model_reset();
    m_seeded     = 1'b0;
    m_seed       = '0;
    m_seed_edge  = -100;
    m_ready_edge = 1 << 30;
    m_adv        = 0;
    m_last       = NR - 1;
    m_gnt        = '0;
    m_rnd        = '0;
    m_wrap       = 1'b0;
    m_err        = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic sw, input logic [NB-1:0] sd, input logic [NR-1:0] rq);
    int e, c, j;
    bit rdy, load_cyc, found;
    ecnt++;
    e        = ecnt;
    rdy      = m_seeded && (e - 1 >= m_ready_edge);
    c        = rdy ? m_adv : m_adv - (m_ready_edge - (e - 1));
    load_cyc = (e - 1 == m_seed_edge);
    if (load_cyc) m_wrap = 1'b0;
    else if (m_seeded && c >= 1 && lfsr_after(m_seed, c) == m_seed) m_wrap = 1'b1;
    if (sw && sd == 4'hF) m_err = 1'b1;
    else if (load_cyc)    m_err = 1'b0;
    m_gnt = '0;
    if (sw && sd != 4'hF) begin
      m_seeded     = 1'b1;
      m_seed       = sd;
      m_seed_edge  = e;
      m_adv        = WU;
      m_ready_edge = e + 1 + WU;
    end else if (rdy && rq != '0) begin
      found = 1'b0;
      for (int k = 1; k <= NR; k++) begin
        j = (m_last + k) % NR;
        if (!found && rq[j]) begin
          found  = 1'b1;
          m_last = j;
        end
      end
      m_gnt = 4'(1 << m_last);
      m_rnd = lfsr_after(m_seed, m_adv);
      exp_q.push_back(m_rnd);
      m_adv        = m_adv + ST;
      m_ready_edge = e + ST;
    end
  endtask

  task automatic check_outputs();
    logic m_busy;
    m_busy = !(m_seeded && ecnt >= m_ready_edge);
    chk("gnt", gnt, m_gnt);
    chk("rnd_valid", rnd_valid, m_gnt != '0);
    chk("rnd_data", rnd_data, m_rnd);
    chk("busy", busy, m_busy);
    chk("wrapped", wrapped, m_wrap);
    chk("seed_err", seed_err, m_err);
    if (rnd_valid) begin
      if (exp_q.size() == 0) chk("sb_extra", rnd_valid, 1'b0);
      else chk("sb_word", rnd_data, exp_q.pop_front());
      seen_rnd.push_back(rnd_data);
      seen_gnt.push_back(gnt);
      seen_edge.push_back(ecnt);
      seen_wrap.push_back(wrapped);
    end
  endtask

  task automatic tick(input logic sw, input logic [NB-1:0] sd, input logic [NR-1:0] rq);
    seed_wr   = sw;
    seed_data = sd;
    req       = rq;
    @(posedge clk);
    model_edge(sw, sd, rq);
    #1;
    check_outputs();
  endtask

  // Asserts rst mid-cycle, checks the asynchronous response, releases after an edge.
  task automatic async_reset();
    #3;
    rst     = 1'b1;
    seed_wr = 1'b0;
    req     = '0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    ecnt++;
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_seen();
    seen_rnd.delete();
    seen_gnt.delete();
    seen_edge.delete();
    seen_wrap.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] basic_exp[4];
    logic [NR-1:0] rr_exp[5];
    logic          sw;
    logic [NB-1:0] sd;
    int            waited;
    basic_exp = '{4'h7, 4'hE, 4'hD, 4'hB};
    rr_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst       = 1'b1;
    seed_wr   = 1'b0;
    seed_data = '0;
    req       = '0;
    model_reset();
    async_reset();

    // No seed: requests are ignored.
    clear_seen();
    repeat (20) tick(1'b0, '0, 4'b0001);
    chk("noseed_busy", busy, 1'b1);
    chk("noseed_grants", seen_gnt.size(), 0);

    // All-ones seed rejected while unseeded.
    tick(1'b1, 4'hF, 4'b0001);
    chk("rej_unseeded_err", seed_err, 1'b1);
    repeat (3) tick(1'b0, '0, 4'b0001);
    chk("rej_unseeded_busy", busy, 1'b1);
    chk("rej_unseeded_grants", seen_gnt.size(), 0);

    // Basic sequence from seed 1.
    clear_seen();
    tick(1'b1, 4'h1, 4'b0001);
    chk("seed_busy_0", busy, 1'b1);
    tick(1'b0, '0, 4'b0001);
    chk("seed_busy_1", busy, 1'b1);
    tick(1'b0, '0, 4'b0001);
    chk("seed_busy_2", busy, 1'b1);
    tick(1'b0, '0, 4'b0001);
    chk("seed_ready", busy, 1'b0);
    repeat (8) tick(1'b0, '0, 4'b0001);
    chk("basic_count", seen_rnd.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (i < seen_rnd.size()) chk("basic_word", seen_rnd[i], basic_exp[i]);
    if (seen_edge.size() >= 2) chk("basic_spacing", seen_edge[1] - seen_edge[0], 2);

    // Round-robin over all four requesters from reset priority.
    async_reset();
    clear_seen();
    tick(1'b1, 4'h1, 4'b0000);
    repeat (14) tick(1'b0, '0, 4'b1111);
    chk("rr_count", seen_gnt.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      if (i < seen_gnt.size()) chk("rr_gnt", seen_gnt[i], rr_exp[i]);

    // Wrap-around, rejected seed while running, then reseed clears wrapped.
    async_reset();
    clear_seen();
    tick(1'b1, 4'h1, 4'b0000);
    repeat (34) tick(1'b0, '0, 4'b0001);
    chk("wrap_count", seen_wrap.size() >= 14, 1'b1);
    if (seen_wrap.size() >= 14) begin
      chk("wrap_before", seen_wrap[12], 1'b0);
      chk("wrap_after", seen_wrap[13], 1'b1);
    end
    tick(1'b1, 4'hF, 4'b0001);
    chk("rej_running_err", seed_err, 1'b1);
    repeat (6) tick(1'b0, '0, 4'b0001);
    tick(1'b1, 4'h1, 4'b0000);
    repeat (2) tick(1'b0, '0, 4'b0000);
    chk("reseed_wrap_clear", wrapped, 1'b0);
    chk("reseed_err_clear", seed_err, 1'b0);

    // Reseed during STEP with a same-cycle request.
    waited = 0;
    tick(1'b0, '0, 4'b0001);
    while (!rnd_valid && waited < 8) begin
      tick(1'b0, '0, 4'b0001);
      waited++;
    end
    chk("mid_wait_grant", rnd_valid, 1'b1);
    tick(1'b1, 4'h1, 4'b0001);
    chk("mid_no_grant", gnt, 4'b0000);
    chk("mid_busy", busy, 1'b1);
    clear_seen();
    repeat (6) tick(1'b0, '0, 4'b0001);
    chk("mid_count", seen_rnd.size() >= 1, 1'b1);
    if (seen_rnd.size() >= 1) chk("mid_first_word", seen_rnd[0], 4'h7);

    // Reset during WARM.
    tick(1'b1, 4'h1, 4'b0000);
    tick(1'b0, '0, 4'b0001);
    async_reset();
    chk("rst_warm_busy", busy, 1'b1);
    chk("rst_warm_gnt", gnt, 4'b0000);
    repeat (4) tick(1'b0, '0, 4'b0001);

    // Random traffic with occasional valid and rejected reseeds.
    tick(1'b1, 4'($urandom_range(0, 14)), '0);
    repeat (300) begin
      sw = ($urandom_range(0, 29) == 0);
      sd = '0;
      if (sw) sd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      tick(sw, sd, 4'($urandom_range(0, 15)));
    end
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
